thread_reg_file: RTL and testbench

Per-thread register file for one compute core: sixteen 8-bit registers feeding `rs`/`rt` to that thread's ALU and LSU, and absorbing results by write-back. One instance per thread, sitting directly upstream of the ALU (operand supply) and downstream of it (`alu_out` write-back). R13–R15 are read-only and hold block ID, block dimension and thread ID so kernels can compute their own indices.

---
 rtl/thread_reg_file_pkg.sv | 30 +++
 rtl/reg_wb_mux.sv | 24 ++
 rtl/thread_reg_file.sv | 69 ++++++
 tb/tb_thread_reg_file.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/thread_reg_file_pkg.sv
// thread_reg_file_pkg: shared encodings and register indices for the per-thread register file.
// Configuration macro: THREAD_REG_FILE_ZERO_REG_EN (when defined, R0 reads as zero and ignores writes).
package thread_reg_file_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_e;
  typedef enum logic [1:0] {
    MUX_ALU      = 2'b00,
    MUX_MEMORY   = 2'b01,
    MUX_CONSTANT = 2'b10,
    MUX_RESERVED = 2'b11
  } reg_mux_e;
  localparam logic [3:0] BLOCK_ID_REG  = 4'd13;
  localparam logic [3:0] BLOCK_DIM_REG = 4'd14;
  localparam logic [3:0] THREAD_ID_REG = 4'd15;
  localparam logic [3:0] LAST_GP_REG   = 4'd12;
  localparam int         NUM_GP_REGS   = 13;
`ifdef THREAD_REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif
endpackage

// File: rtl/reg_wb_mux.sv
// reg_wb_mux: write-back source select and write qualification for the thread register file.
// Ports: update (enabled UPDATE-state write request), sel (source select), rd (destination),
//        alu_out/lsu_out/immediate (candidate sources), wr_en/wr_data (qualified write).
// Configuration macro: THREAD_REG_FILE_ZERO_REG_EN (via package ZERO_REG_EN) blocks writes to R0.
module reg_wb_mux
  import thread_reg_file_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 update,
  input  logic [1:0]           sel,
  input  logic [3:0]           rd,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic [DATA_BITS-1:0] immediate,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data
);
  always_comb begin
    wr_data = sel == MUX_ALU ? alu_out : sel == MUX_MEMORY ? lsu_out : immediate;
    // reserved select and the read-only R13-R15 silently drop the write
    wr_en = update && sel != MUX_RESERVED && rd <= LAST_GP_REG && !(ZERO_REG_EN && rd == 4'd0);
  end
endmodule

// File: rtl/thread_reg_file.sv
// thread_reg_file: per-thread 16-entry register file supplying rs/rt operands and absorbing write-back.
// Ports: clk, reset (async, active-high), enable (thread active), block_id (mirrored into R13),
//        core_state, decoded_* (instruction fields), alu_out/lsu_out (write-back sources),
//        rs/rt (registered operands, updated only in REQUEST).
// Configuration macro: THREAD_REG_FILE_ZERO_REG_EN (R0 hardwired to zero).
module thread_reg_file
  import thread_reg_file_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);
  logic [DATA_BITS-1:0] gp [NUM_GP_REGS];
  logic [DATA_BITS-1:0] r13;
  logic [DATA_BITS-1:0] rs_val, rt_val, wr_data;
  logic                 wr_en;
  reg_wb_mux #(.DATA_BITS(DATA_BITS)) u_wb (
    .update    (enable && core_state == UPDATE && decoded_reg_write_enable),
    .sel       (decoded_reg_input_mux),
    .rd        (decoded_rd_address),
    .alu_out   (alu_out),
    .lsu_out   (lsu_out),
    .immediate (decoded_immediate),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );
  // R14/R15 are constants, so they are decoded here instead of being stored
  always_comb begin
    rs_val = decoded_rs_address == BLOCK_ID_REG  ? r13 :
             decoded_rs_address == BLOCK_DIM_REG ? DATA_BITS'(THREADS_PER_BLOCK) :
             decoded_rs_address == THREAD_ID_REG ? DATA_BITS'(THREAD_ID) :
             (ZERO_REG_EN && decoded_rs_address == 4'd0) ? '0 : gp[decoded_rs_address];
    rt_val = decoded_rt_address == BLOCK_ID_REG  ? r13 :
             decoded_rt_address == BLOCK_DIM_REG ? DATA_BITS'(THREADS_PER_BLOCK) :
             decoded_rt_address == THREAD_ID_REG ? DATA_BITS'(THREAD_ID) :
             (ZERO_REG_EN && decoded_rt_address == 4'd0) ? '0 : gp[decoded_rt_address];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GP_REGS; i++) gp[i] <= '0;
      r13 <= '0;
      rs  <= '0;
      rt  <= '0;
    end else if (enable) begin
      r13 <= DATA_BITS'(block_id);
      if (core_state == REQUEST) begin
        rs <= rs_val;
        rt <= rt_val;
      end
      if (wr_en) gp[decoded_rd_address] <= wr_data;
    end
  end
endmodule

// File: tb/tb_thread_reg_file.sv
// tb_thread_reg_file: directed plus randomized checks of thread_reg_file against a behavioural model.
module tb_thread_reg_file;
  localparam int TPB = 4;
  localparam int TID = 2;
`ifdef THREAD_REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] block_id = 8'h00;
  logic [2:0] core_state = 3'd0;
  logic [3:0] rd_a = 4'd0, rs_a = 4'd0, rt_a = 4'd0;
  logic       we = 1'b0;
  logic [1:0] mux = 2'd0;
  logic [7:0] imm = 8'h00, alu = 8'h00, lsu = 8'h00;
  logic [7:0] rs, rt;
  int checks = 0;
  int failures = 0;
  thread_reg_file #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .block_id                 (block_id),
    .core_state               (core_state),
    .decoded_rd_address       (rd_a),
    .decoded_rs_address       (rs_a),
    .decoded_rt_address       (rt_a),
    .decoded_reg_write_enable (we),
    .decoded_reg_input_mux    (mux),
    .decoded_immediate        (imm),
    .alu_out                  (alu),
    .lsu_out                  (lsu),
    .rs                       (rs),
    .rt                       (rt)
  );
  always #5 clk = ~clk;
  logic [7:0] m_reg [16];
  logic [7:0] m_rs, m_rt;
  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a == 4'd14) return 8'(TPB);
    if (a == 4'd15) return 8'(TID);
    if (ZR && a == 4'd0) return 8'h00;
    return m_reg[a];
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      m_rs = 8'h00;
      m_rt = 8'h00;
    end else if (enable) begin
      if (core_state == 3'd3) begin
        m_rs = m_read(rs_a);
        m_rt = m_read(rt_a);
      end
      if (core_state == 3'd6 && we && mux != 2'd3 && rd_a <= 4'd12 && !(ZR && rd_a == 4'd0))
        m_reg[rd_a] = mux == 2'd0 ? alu : mux == 2'd1 ? lsu : imm;
      m_reg[13] = block_id;
    end
  end
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic [2:0] st, input logic [3:0] d, s, t,
                     input logic w, input logic [1:0] m, input logic [7:0] i, a, l);
    enable = e; core_state = st; rd_a = d; rs_a = s; rt_a = t;
    we = w; mux = m; imm = i; alu = a; lsu = l;
    @(posedge clk);
    @(negedge clk);
    check("model_rs", rs, m_rs);
    check("model_rt", rt, m_rt);
  endtask
  initial begin
    #1;
    check("reset_rs", rs, 8'h00);
    check("reset_rt", rt, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 3'd6, 4'd1, 4'd0, 4'd0, 1, 2'd2, 8'h2A, 8'h00, 8'h00);
    cyc(1, 3'd3, 4'd0, 4'd1, 4'd15, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("const_r1", rs, 8'h2A);
    check("thread_id", rt, 8'h02);
    cyc(1, 3'd6, 4'd5, 4'd0, 4'd0, 1, 2'd0, 8'h00, 8'h7F, 8'h00);
    cyc(1, 3'd6, 4'd6, 4'd0, 4'd0, 1, 2'd1, 8'h00, 8'h00, 8'h81);
    cyc(1, 3'd3, 4'd0, 4'd5, 4'd6, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("alu_wb", rs, 8'h7F);
    check("lsu_wb", rt, 8'h81);
    block_id = 8'h33;
    cyc(1, 3'd6, 4'd14, 4'd0, 4'd0, 1, 2'd2, 8'h99, 8'h00, 8'h00);
    cyc(1, 3'd6, 4'd13, 4'd0, 4'd0, 1, 2'd2, 8'h99, 8'h00, 8'h00);
    cyc(1, 3'd6, 4'd2, 4'd0, 4'd0, 1, 2'd3, 8'h99, 8'h99, 8'h99);
    cyc(1, 3'd3, 4'd0, 4'd14, 4'd13, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("r14_ro", rs, 8'h04);
    check("r13_blk", rt, 8'h33);
    cyc(1, 3'd3, 4'd0, 4'd2, 4'd2, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("mux11_nowr", rs, 8'h00);
    cyc(1, 3'd3, 4'd0, 4'd5, 4'd6, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    block_id = 8'h77;
    cyc(0, 3'd3, 4'd0, 4'd1, 4'd2, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("dis_rs", rs, 8'h7F);
    check("dis_rt", rt, 8'h81);
    cyc(0, 3'd6, 4'd4, 4'd0, 4'd0, 1, 2'd2, 8'h44, 8'h00, 8'h00);
    cyc(1, 3'd3, 4'd0, 4'd4, 4'd13, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("dis_nowr", rs, 8'h00);
    check("dis_r13_hold", rt, 8'h33);
    cyc(1, 3'd3, 4'd0, 4'd13, 4'd13, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("r13_reload", rs, 8'h77);
    cyc(1, 3'd6, 4'd0, 4'd0, 4'd0, 1, 2'd2, 8'h11, 8'h00, 8'h00);
    cyc(1, 3'd3, 4'd0, 4'd0, 4'd0, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("zero_reg", rs, ZR ? 8'h00 : 8'h11);
    cyc(1, 3'd6, 4'd3, 4'd0, 4'd0, 1, 2'd0, 8'h00, 8'h5A, 8'h00);
    cyc(1, 3'd3, 4'd0, 4'd3, 4'd3, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("r3_pre", rs, 8'h5A);
    core_state = 3'd5;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rs", rs, 8'h00);
    check("async_rt", rt, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 3'd3, 4'd0, 4'd14, 4'd15, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("rst_r14", rs, 8'h04);
    check("rst_r15", rt, 8'h02);
    cyc(1, 3'd3, 4'd0, 4'd3, 4'd1, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    check("rst_r3", rs, 8'h00);
    check("rst_r1", rt, 8'h00);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_rst_rs", rs, 8'h00);
        check("rand_rst_rt", rt, 8'h00);
        @(negedge clk);
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) block_id = 8'($urandom);
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0 ? 3'($urandom_range(0, 7)) :
          ($urandom_range(0, 1) != 0 ? 3'd3 : 3'd6),
          4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
